reg_file: RTL and testbench

- General-purpose register file for the CPU datapath, directly downstream of the control unit.
- Consumes the control unit's reg-file strobes: oe_a/oe_b, ld, sel_a/sel_b, count_a/count_b.
- Drives operands onto the A and B buses feeding the ALU, MAR and MDR, and writes back results from the result bus.
- Applies per-port post-increments so the control unit can advance PC and SP without using the ALU.

---
 rtl/reg_file.sv | 122 ++++++++++++
 tb/tb_reg_file.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file: general-purpose register file for the CPU datapath.
// Two read ports (A/B) with output gating and one write port sharing the
// A index. Each port also carries a post-increment so PC/SP can advance
// without the ALU. Reads are combinational and return pre-edge state.
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int                WIDTH    = 32,
  parameter int                NUM_REGS = 16,
  parameter int                PC_INDEX = 15,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             oe_a,
  input  logic             oe_b,
  input  logic             ld,
  input  logic [3:0]       sel_a,
  input  logic [3:0]       sel_b,
  input  logic [7:0]       count_a,
  input  logic [7:0]       count_b,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] pc_out
);

  localparam int SEL_W = 4;

  // NUM_REGS expressed at select width + 1 so index range checks never
  // truncate, even when NUM_REGS is exactly 16.
  localparam logic [SEL_W:0] NUM_REGS_W = (SEL_W + 1)'(NUM_REGS);

  // Register storage.
  logic [WIDTH-1:0] regs_r [NUM_REGS];

  // Next-state values for every register, computed in one place.
  logic [WIDTH-1:0] regs_nxt_s [NUM_REGS];

  // Zero-extended increments.
  logic [WIDTH-1:0] inc_a_s;
  logic [WIDTH-1:0] inc_b_s;

  // Select range flags (only relevant when NUM_REGS < 16).
  logic             sel_a_ok_s;
  logic             sel_b_ok_s;

  // Zero-extend the per-port counts and qualify selects against NUM_REGS.
  always_comb begin
    inc_a_s    = {{(WIDTH-8){1'b0}}, count_a};
    inc_b_s    = {{(WIDTH-8){1'b0}}, count_b};
    sel_a_ok_s = ({1'b0, sel_a} < NUM_REGS_W);
    sel_b_ok_s = ({1'b0, sel_b} < NUM_REGS_W);
  end

  // Per-register next value: a load on the A index beats every count on
  // that register; otherwise any count(s) hitting the register are summed
  // into a single wrapping add, which merges the sel_a == sel_b case.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      logic             hit_a;
      logic             hit_b;
      logic [WIDTH-1:0] add_v;
      hit_a = (sel_a == i[SEL_W-1:0]);
      hit_b = (sel_b == i[SEL_W-1:0]);
      add_v = {WIDTH{1'b0}};
      if (ld && hit_a) begin
        regs_nxt_s[i] = data_in;
      end else begin
        if (hit_a) begin
          add_v = add_v + inc_a_s;
        end else begin
          add_v = add_v;
        end
        if (hit_b) begin
          add_v = add_v + inc_b_s;
        end else begin
          add_v = add_v;
        end
        regs_nxt_s[i] = regs_r[i] + add_v;
      end
    end
  end

  // State update: synchronous reset clears everything except the PC,
  // which takes RESET_PC; reset discards any same-cycle load or count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        if (i == PC_INDEX) begin
          regs_r[i] <= RESET_PC;
        end else begin
          regs_r[i] <= {WIDTH{1'b0}};
        end
      end else begin
        regs_r[i] <= regs_nxt_s[i];
      end
    end
  end

  // Combinational read ports, gated to zero when disabled or out of range.
  always_comb begin
    a_out = {WIDTH{1'b0}};
    b_out = {WIDTH{1'b0}};
    if (oe_a && sel_a_ok_s) begin
      a_out = regs_r[sel_a];
    end else begin
      a_out = {WIDTH{1'b0}};
    end
    if (oe_b && sel_b_ok_s) begin
      b_out = regs_r[sel_b];
    end else begin
      b_out = {WIDTH{1'b0}};
    end
  end

  // Program counter is always visible for debug and branch logic.
  always_comb begin
    pc_out = regs_r[PC_INDEX];
  end

endmodule

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file: directed self-checking bench for reg_file.
// ---------------------------------------------------------------------------
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        oe_a;
  logic        oe_b;
  logic        ld;
  logic [3:0]  sel_a;
  logic [3:0]  sel_b;
  logic [7:0]  count_a;
  logic [7:0]  count_b;
  logic [31:0] data_in;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [31:0] pc_out;

  int total_cnt;
  int bad_cnt;
  logic [31:0] rd_val;

  reg_file #(
    .WIDTH(32), .NUM_REGS(16), .PC_INDEX(15), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .oe_a(oe_a), .oe_b(oe_b), .ld(ld),
    .sel_a(sel_a), .sel_b(sel_b), .count_a(count_a), .count_b(count_b),
    .data_in(data_in), .a_out(a_out), .b_out(b_out), .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; oe_a = 1'b0; oe_b = 1'b0; ld = 1'b0;
    count_a = 8'd0; count_b = 8'd0; data_in = 32'd0;
  endtask

  task automatic read_reg(input logic [3:0] idx, output logic [31:0] val);
    ld = 1'b0; count_a = 8'd0; count_b = 8'd0;
    oe_a = 1'b1; sel_a = idx;
    #1;
    val = a_out;
    oe_a = 1'b0;
    #1;
  endtask

  task automatic write_reg(input logic [3:0] idx, input logic [31:0] val);
    idle();
    ld = 1'b1; sel_a = idx; sel_b = 4'd0; data_in = val;
    tick();
    idle();
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    idle();
    sel_a = 4'd0; sel_b = 4'd0;

    // Reset with a competing load on reg3
    rst = 1'b1; ld = 1'b1; sel_a = 4'd3; data_in = 32'hDEAD_BEEF;
    tick();
    idle();
    #1;
    check("rst_a_out", a_out, 32'h0);
    check("rst_b_out", b_out, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    read_reg(4'd3, rd_val);
    check("rst_reg3", rd_val, 32'h0);

    // Write then read; same-cycle read sees old value
    ld = 1'b1; sel_a = 4'd2; data_in = 32'h1234_5678; oe_a = 1'b1;
    #1;
    check("rdw_old", a_out, 32'h0);
    tick();
    idle();
    oe_b = 1'b1; sel_b = 4'd2;
    #1;
    check("wr_rd_b", b_out, 32'h1234_5678);
    idle();

    // PC fetch increment with and without oe_b
    write_reg(4'd15, 32'h0000_0100);
    oe_b = 1'b1; sel_b = 4'd15; count_b = 8'd4; sel_a = 4'd0;
    #1;
    check("pc_fetch_b", b_out, 32'h0000_0100);
    tick();
    idle();
    #1;
    check("pc_inc", pc_out, 32'h0000_0104);
    sel_b = 4'd15; count_b = 8'd4;
    #1;
    check("pc_noe_b", b_out, 32'h0);
    tick();
    idle();
    #1;
    check("pc_inc_noe", pc_out, 32'h0000_0108);

    // Collision: ld with sel_a == sel_b, data wins
    ld = 1'b1; sel_a = 4'd5; sel_b = 4'd5; data_in = 32'd7;
    count_a = 8'd1; count_b = 8'd2;
    tick();
    idle();
    read_reg(4'd5, rd_val);
    check("col_ld", rd_val, 32'd7);

    // Collision: no ld, combined add
    write_reg(4'd5, 32'd10);
    sel_a = 4'd5; sel_b = 4'd5; count_a = 8'd1; count_b = 8'd2;
    tick();
    idle();
    read_reg(4'd5, rd_val);
    check("col_add", rd_val, 32'd13);

    // ld on A with distinct B: count_a dropped, count_b applied
    ld = 1'b1; sel_a = 4'd6; data_in = 32'h55; count_a = 8'd9;
    sel_b = 4'd5; count_b = 8'd3;
    tick();
    idle();
    read_reg(4'd6, rd_val);
    check("ld_split_a", rd_val, 32'h55);
    read_reg(4'd5, rd_val);
    check("ld_split_b", rd_val, 32'd16);

    // Wrap-around
    write_reg(4'd4, 32'hFFFF_FFFE);
    sel_a = 4'd4; sel_b = 4'd0; count_a = 8'd4;
    tick();
    idle();
    read_reg(4'd4, rd_val);
    check("wrap", rd_val, 32'h0000_0002);
    sel_a = 4'd4; sel_b = 4'd4; count_a = 8'd255; count_b = 8'd255;
    tick();
    idle();
    read_reg(4'd4, rd_val);
    check("max_counts", rd_val, 32'h0000_0200);

    // Output gating
    sel_a = 4'd2; sel_b = 4'd5;
    #1;
    check("gate_a0", a_out, 32'h0);
    check("gate_b0", b_out, 32'h0);
    oe_a = 1'b1;
    #1;
    check("gate_a1", a_out, 32'h1234_5678);
    check("gate_b_off", b_out, 32'h0);
    idle();

    // Reset mid-operation
    rst = 1'b1; ld = 1'b1; sel_a = 4'd2; data_in = 32'h99;
    sel_b = 4'd15; count_b = 8'd5;
    tick();
    idle();
    #1;
    check("mid_rst_pc", pc_out, 32'h0);
    read_reg(4'd2, rd_val);
    check("mid_rst_r2", rd_val, 32'h0);
    read_reg(4'd5, rd_val);
    check("mid_rst_r5", rd_val, 32'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
